// File: rtl/uart_tx_arb_pkg.sv
// Shared constants for the UART transmitter arbiter: one-hot FSM encoding and sizing limits.
// Latency: n/a (declarations only). Backpressure: n/a.
package uart_tx_arb_pkg;

    localparam int N_REQ_MAX        = 4;
    localparam int RISE_TIMEOUT_DEF = 64;

    typedef enum logic [3:0] {
        S_IDLE      = 4'b0001,
        S_WAIT_RISE = 4'b0010,
        S_WAIT_FALL = 4'b0100,
        S_NEXT      = 4'b1000
    } state_t;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of req_valid searched upward from rr_ptr, with wrap.
// Latency: combinational. Backpressure: none; found=0 when nothing is requesting.
module rr_picker
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic [N_REQ-1:0] req_valid,
    input  logic [1:0]       rr_ptr,
    output logic [1:0]       winner,
    output logic             found
);

    logic [N_REQ_MAX-1:0] vld_pad;
    logic [2:0]           idx;

    assign vld_pad = N_REQ_MAX'(req_valid);

    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = {1'b0, rr_ptr} + 3'(k);
            if (idx >= 3'(N_REQ)) begin
                idx = idx - 3'(N_REQ);
            end
            if (!found && vld_pad[idx[1:0]]) begin
                winner = idx[1:0];
                found  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Frame-granular round-robin arbiter sharing one UART byte transmitter among N_REQ requesters.
// Latency: 1 cycle from a winning req_valid (IDLE or NEXT) to txd_en_go, req_ready and txd_data.
// Backpressure: one req_ready pulse per captured byte; pacing follows the synchronized txd_busy level.
module uart_tx_arbiter
    import uart_tx_arb_pkg::*;
#(
    parameter int N_REQ        = 2,
    parameter int RISE_TIMEOUT = RISE_TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    output logic [7:0]         txd_data,
    output logic               txd_en_go,
    input  logic               txd_busy,
    output logic [1:0]         grant_id,
    output logic               frame_active,
    output logic               err_timeout
);

    localparam int CW = (RISE_TIMEOUT > 1) ? $clog2(RISE_TIMEOUT) : 1;

    state_t                 state;
    state_t                 state_d;
    logic [1:0]             bs;
    logic [CW-1:0]          cnt;
    logic [1:0]             rr_ptr;
    logic [1:0]             pick;
    logic [1:0]             load_idx;
    logic [1:0]             ptr_inc;
    logic                   found;
    logic                   last_q;
    logic                   load;
    logic                   end_frame;
    logic                   timeout;
    logic                   rise;
    logic                   fall;
    logic [N_REQ_MAX-1:0]   vld_pad;
    logic [N_REQ_MAX-1:0]   last_pad;
    logic [N_REQ_MAX-1:0]   sel_oh;
    logic [8*N_REQ_MAX-1:0] data_pad;

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .req_valid (req_valid),
        .rr_ptr    (rr_ptr),
        .winner    (pick),
        .found     (found)
    );

    assign vld_pad  = N_REQ_MAX'(req_valid);
    assign last_pad = N_REQ_MAX'(req_last);
    assign data_pad = (8*N_REQ_MAX)'(req_data);
    assign sel_oh   = N_REQ_MAX'(1) << load_idx;
    assign rise     = (bs == 2'b01);
    assign fall     = (bs == 2'b10);
    assign ptr_inc  = (grant_id == 2'(N_REQ - 1)) ? 2'd0 : grant_id + 2'd1;

    // Edges are judged only on synchronized busy, never in the same cycle as a new capture.
    always_comb begin
        state_d   = state;
        load      = 1'b0;
        load_idx  = grant_id;
        end_frame = 1'b0;
        timeout   = 1'b0;
        case (state)
            S_IDLE: begin
                if (found && !bs[1]) begin
                    load     = 1'b1;
                    load_idx = pick;
                    state_d  = S_WAIT_RISE;
                end
            end
            S_WAIT_RISE: begin
                if (rise) begin
                    state_d = S_WAIT_FALL;
                end else if (cnt == CW'(RISE_TIMEOUT - 1)) begin
                    timeout   = 1'b1;
                    end_frame = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_WAIT_FALL: begin
                if (fall) begin
                    if (last_q) begin
                        end_frame = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_NEXT;
                    end
                end
            end
            S_NEXT: begin
                if (vld_pad[grant_id]) begin
                    load    = 1'b1;
                    state_d = S_WAIT_RISE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            bs           <= 2'b00;
            cnt          <= '0;
            rr_ptr       <= 2'd0;
            last_q       <= 1'b0;
            txd_data     <= 8'h00;
            txd_en_go    <= 1'b0;
            req_ready    <= '0;
            grant_id     <= 2'd0;
            frame_active <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state       <= state_d;
            bs          <= {bs[0], txd_busy};
            cnt         <= (state == S_WAIT_RISE) ? cnt + CW'(1) : '0;
            txd_en_go   <= load;
            err_timeout <= timeout;
            req_ready   <= load ? N_REQ'(sel_oh) : '0;
            if (load) begin
                txd_data     <= data_pad[{load_idx, 3'b000} +: 8];
                grant_id     <= load_idx;
                frame_active <= 1'b1;
                last_q       <= last_pad[load_idx];
            end
            if (end_frame) begin
                frame_active <= 1'b0;
                rr_ptr       <= ptr_inc;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: frame tables for lock/round-robin/gap, hand sequences for
// first-byte latency, reset values, reset mid-frame and busy-rise timeout.
module tb_uart_tx_arbiter;

    localparam int NR       = 2;
    localparam int RT       = 16;
    localparam int BUSY_LEN = 6;

    typedef struct { int scn; int req; logic [7:0] d; logic last; int gap; int after; } stim_t;
    typedef struct { int scn; logic [7:0] d; logic [1:0] g; } exp_t;
    typedef struct { logic [7:0] d; logic last; int gap; } item_t;
    typedef struct { logic [7:0] d; logic [1:0] g; int cyc; } send_t;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req_valid;
    logic [8*NR-1:0] req_data;
    logic [NR-1:0]   req_last;
    logic [NR-1:0]   req_ready;
    logic [7:0]      txd_data;
    logic            txd_en_go;
    logic            txd_busy;
    logic [1:0]      grant_id;
    logic            frame_active;
    logic            err_timeout;

    int    checks = 0;
    int    errors = 0;
    int    cyc    = 0;
    item_t rq[NR][$];
    int    gapc[NR];
    int    cur_gap[NR];
    int    pres_cyc[NR];
    item_t drv_it;
    send_t log_q[$];
    int    err_q[$];
    logic  no_busy;
    int    bcnt;
    stim_t st[$];
    exp_t  ex[$];

    uart_tx_arbiter #(.N_REQ(NR), .RISE_TIMEOUT(RT)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .txd_data     (txd_data),
        .txd_en_go    (txd_en_go),
        .txd_busy     (txd_busy),
        .grant_id     (grant_id),
        .frame_active (frame_active),
        .err_timeout  (err_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Requesters: hold a byte until req_ready, then idle for the item's gap before the next one.
    initial begin
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        for (int i = 0; i < NR; i++) begin
            gapc[i]     = 0;
            cur_gap[i]  = 0;
            pres_cyc[i] = 0;
        end
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i]) begin
                    if (req_ready[i]) begin
                        req_valid[i] = 1'b0;
                        gapc[i]      = cur_gap[i];
                    end
                end else if (gapc[i] > 0) begin
                    gapc[i]--;
                end else if (rq[i].size() > 0) begin
                    drv_it             = rq[i].pop_front();
                    req_data[8*i +: 8] = drv_it.d;
                    req_last[i]        = drv_it.last;
                    cur_gap[i]         = drv_it.gap;
                    req_valid[i]       = 1'b1;
                    pres_cyc[i]        = cyc;
                end
            end
        end
    end

    // Transmitter model: busy goes high right after txd_en_go and stays for BUSY_LEN cycles.
    initial begin
        txd_busy = 1'b0;
        bcnt     = 0;
        forever begin
            @(negedge clk);
            if (txd_en_go && !no_busy) bcnt = BUSY_LEN;
            else if (bcnt > 0) bcnt--;
            txd_busy = (bcnt > 0);
        end
    end

    always @(negedge clk) begin
        if (txd_en_go) begin
            log_q.push_back(send_t'{txd_data, grant_id, cyc});
            chk("ready_onehot", 32'(req_ready), 32'(1) << grant_id);
        end
        if (err_timeout) err_q.push_back(cyc);
    end

    task automatic wait_sends(input int n, input string name);
        int b = 0;
        while (log_q.size() < n && b < 400) begin
            step(1);
            b++;
        end
        if (log_q.size() < n) chk({name, "_send_wait"}, 32'(log_q.size()), 32'(n));
    endtask

    task automatic wait_idle(input string name);
        int b = 0;
        while ((frame_active || txd_busy) && b < 200) begin
            step(1);
            b++;
        end
        if (frame_active || txd_busy) chk({name, "_idle_wait"}, 32'(frame_active), 32'(0));
    endtask

    task automatic check_reset_vals(input string name);
        chk({name, "_req_ready"}, 32'(req_ready), 32'(0));
        chk({name, "_txd_en_go"}, 32'(txd_en_go), 32'(0));
        chk({name, "_err"}, 32'(err_timeout), 32'(0));
        chk({name, "_frame_active"}, 32'(frame_active), 32'(0));
        chk({name, "_txd_data"}, 32'(txd_data), 32'h00);
        chk({name, "_grant_id"}, 32'(grant_id), 32'(0));
    endtask

    task automatic run_scn(input int s, input string name);
        int k = 0;
        int n = 0;
        log_q.delete();
        foreach (ex[j]) if (ex[j].scn == s) n++;
        foreach (st[j]) begin
            if (st[j].scn == s) begin
                if (st[j].after > 0) wait_sends(st[j].after, name);
                rq[st[j].req].push_back(item_t'{st[j].d, st[j].last, st[j].gap});
            end
        end
        wait_sends(n, name);
        foreach (ex[j]) begin
            if (ex[j].scn == s) begin
                if (k < log_q.size()) begin
                    chk({name, "_data"}, 32'(log_q[k].d), 32'(ex[j].d));
                    chk({name, "_grant"}, 32'(log_q[k].g), 32'(ex[j].g));
                end else begin
                    chk({name, "_missing"}, 32'(log_q.size()), 32'(k + 1));
                end
                k++;
            end
        end
        wait_idle(name);
    endtask

    initial begin
        int b;
        // scn 2: frame lock; scn 3: round robin; scn 5: gap inside a frame
        st.push_back(stim_t'{2, 0, 8'h34, 1'b0, 0, 0});
        st.push_back(stim_t'{2, 0, 8'h12, 1'b1, 0, 0});
        st.push_back(stim_t'{2, 1, 8'h56, 1'b1, 0, 1});
        for (int i = 0; i < 4; i++) begin
            st.push_back(stim_t'{3, 0, 8'(8'h01 + i), 1'b1, 0, 0});
            st.push_back(stim_t'{3, 1, 8'(8'h81 + i), 1'b1, 0, 0});
        end
        st.push_back(stim_t'{5, 1, 8'hB1, 1'b0, 20, 0});
        st.push_back(stim_t'{5, 1, 8'hB2, 1'b1, 0, 0});
        st.push_back(stim_t'{5, 0, 8'hC0, 1'b1, 0, 1});

        ex.push_back(exp_t'{2, 8'h34, 2'd0});
        ex.push_back(exp_t'{2, 8'h12, 2'd0});
        ex.push_back(exp_t'{2, 8'h56, 2'd1});
        for (int i = 0; i < 4; i++) begin
            ex.push_back(exp_t'{3, 8'(8'h01 + i), 2'd0});
            ex.push_back(exp_t'{3, 8'(8'h81 + i), 2'd1});
        end
        ex.push_back(exp_t'{5, 8'hB1, 2'd1});
        ex.push_back(exp_t'{5, 8'hB2, 2'd1});
        ex.push_back(exp_t'{5, 8'hC0, 2'd0});

        rst     = 1'b1;
        no_busy = 1'b0;
        step(3);
        check_reset_vals("reset");
        rst = 1'b0;

        // Single one-byte frame: latency, one-cycle ready, frame_active drop on synchronized fall
        log_q.delete();
        rq[0].push_back(item_t'{8'hA5, 1'b1, 0});
        wait_sends(1, "single");
        if (log_q.size() > 0) begin
            chk("single_data", 32'(log_q[0].d), 32'hA5);
            chk("single_grant", 32'(log_q[0].g), 32'(0));
            chk("single_latency", 32'(log_q[0].cyc - pres_cyc[0]), 32'(1));
        end
        step(1);
        chk("single_ready_pulse", 32'(req_ready), 32'(0));
        b = 0;
        while (txd_busy && b < 50) begin
            step(1);
            b++;
        end
        step(1);
        chk("single_active_at_fall", 32'(frame_active), 32'(1));
        step(1);
        chk("single_active_drop", 32'(frame_active), 32'(0));
        wait_idle("single");

        run_scn(2, "lock");
        run_scn(3, "rr");
        run_scn(5, "gap");
        if (log_q.size() >= 2) chk("gap_hold", 32'(log_q[1].cyc - log_q[0].cyc > 20), 32'(1));

        // Reset while the frame of requester 1 sits in WAIT_FALL
        log_q.delete();
        rq[1].push_back(item_t'{8'hF1, 1'b0, 0});
        rq[1].push_back(item_t'{8'hF2, 1'b1, 0});
        wait_sends(1, "midrst");
        if (log_q.size() > 0) chk("midrst_first_grant", 32'(log_q[0].g), 32'(1));
        step(3);
        chk("midrst_locked", 32'(frame_active), 32'(1));
        rst = 1'b1;
        rq[0].push_back(item_t'{8'hA0, 1'b1, 0});
        step(1);
        check_reset_vals("midrst");
        rst = 1'b0;
        log_q.delete();
        wait_sends(2, "midrst");
        if (log_q.size() >= 2) begin
            chk("midrst_after_data0", 32'(log_q[0].d), 32'hA0);
            chk("midrst_after_grant0", 32'(log_q[0].g), 32'(0));
            chk("midrst_after_data1", 32'(log_q[1].d), 32'hF2);
            chk("midrst_after_grant1", 32'(log_q[1].g), 32'(1));
        end
        wait_idle("midrst");

        // Busy never rises: timeout pulse, frame released, next requester in rotation served
        no_busy = 1'b1;
        log_q.delete();
        err_q.delete();
        rq[0].push_back(item_t'{8'hD0, 1'b1, 0});
        wait_sends(1, "tmo");
        rq[0].push_back(item_t'{8'hD1, 1'b1, 0});
        rq[1].push_back(item_t'{8'hE1, 1'b1, 0});
        b = 0;
        while (!err_timeout && b < 100) begin
            step(1);
            b++;
        end
        chk("tmo_pulse", 32'(err_timeout), 32'(1));
        chk("tmo_frame_drop", 32'(frame_active), 32'(0));
        no_busy = 1'b0;
        if (err_q.size() > 0 && log_q.size() > 0)
            chk("tmo_delay", 32'(err_q[0] - log_q[0].cyc), 32'(RT));
        step(1);
        chk("tmo_single_pulse", 32'(err_timeout), 32'(0));
        wait_sends(3, "tmo");
        if (log_q.size() >= 3 && err_q.size() > 0) begin
            chk("tmo_first_grant", 32'(log_q[0].g), 32'(0));
            chk("tmo_next_data", 32'(log_q[1].d), 32'hE1);
            chk("tmo_next_grant", 32'(log_q[1].g), 32'(1));
            chk("tmo_next_cycle", 32'(log_q[1].cyc - err_q[0]), 32'(1));
            chk("tmo_last_data", 32'(log_q[2].d), 32'hD1);
            chk("tmo_last_grant", 32'(log_q[2].g), 32'(0));
        end
        wait_idle("tmo");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
